quadrilatero_rw_queue_dispatcher: RTL and testbench

// - Converts one issued matrix instruction (up to N_SRC source tiles + 1 dest tile) into per-register
//   rw_queue entries and pushes them into the RF sequencer's per-register FIFOs (rw_queue_entry/push).
// - Absorbs per-register full backpressure by pushing each target register independently as space frees.
// - Sits between the instruction dispatcher and quadrilatero_rf_sequencer; preserves instruction order per register.

---
 rtl/quadrilatero_pkg.sv | 23 ++
 rtl/quadrilatero_operand_merge.sv | 47 ++++
 rtl/quadrilatero_rw_queue_dispatcher.sv | 120 ++++++++++++
 tb/tb_quadrilatero_rw_queue_dispatcher.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/quadrilatero_pkg.sv
// rtl/quadrilatero_pkg.sv - shared types for the quadrilatero matrix register-file path
package quadrilatero_pkg;

  // Default instruction id width seen on the issue interface
  localparam int X_ID_WIDTH = 4;

  // Dispatcher control states
  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } dispatcher_state_e;

  // One per-register queue entry; bit layout {id, wready, rvalid}
  typedef struct packed {
    logic [X_ID_WIDTH-1:0] id;
    logic                  wready;
    logic                  rvalid;
  } rw_queue_t;

  localparam int RWQ_RVALID_BIT = 0;
  localparam int RWQ_WREADY_BIT = 1;

endpackage

// File: rtl/quadrilatero_operand_merge.sv
// rtl/quadrilatero_operand_merge.sv - folds source/dest operand lists into per-register queue entries
module quadrilatero_operand_merge
  import quadrilatero_pkg::*;
#(
  parameter int N_REGS   = 8,
  parameter int N_SRC    = 3,
  parameter int ID_WIDTH = X_ID_WIDTH,
  parameter int AW       = $clog2(N_REGS),
  parameter int EW       = ID_WIDTH + 2
) (
  input  logic [ID_WIDTH-1:0]    instr_id_i,
  input  logic [N_SRC*AW-1:0]    rs_addr_i,
  input  logic [N_SRC-1:0]       rs_valid_i,
  input  logic [AW-1:0]          rd_addr_i,
  input  logic                   rd_valid_i,
  output logic [N_REGS*EW-1:0]   entries_o,
  output logic [N_REGS-1:0]      target_o
);

  logic [N_REGS-1:0] rvalid;
  logic [N_REGS-1:0] wready;

  // A register is read if any used source names it; duplicates collapse into one bit
  always_comb begin
    rvalid = '0;
    wready = '0;
    for (int r = 0; r < N_REGS; r++) begin
      for (int i = 0; i < N_SRC; i++) begin
        if (rs_valid_i[i] && (rs_addr_i[i*AW +: AW] == AW'(r))) begin
          rvalid[r] = 1'b1;
        end
      end
      wready[r] = rd_valid_i && (rd_addr_i == AW'(r));
    end
  end

  // Pack each register's entry; rs==rd yields one entry with both bits (read-before-write)
  always_comb begin
    entries_o = '0;
    target_o  = '0;
    for (int r = 0; r < N_REGS; r++) begin
      entries_o[r*EW +: EW] = {instr_id_i, wready[r], rvalid[r]};
      target_o[r]           = rvalid[r] | wready[r];
    end
  end

endmodule

// File: rtl/quadrilatero_rw_queue_dispatcher.sv
// rtl/quadrilatero_rw_queue_dispatcher.sv - pushes one instruction's per-register entries into the RF sequencer queues
module quadrilatero_rw_queue_dispatcher
  import quadrilatero_pkg::*;
#(
  parameter int N_REGS    = 8,
  parameter int N_SRC     = 3,
  parameter int ID_WIDTH  = X_ID_WIDTH,
  parameter int CNT_WIDTH = 16,
  parameter int AW        = $clog2(N_REGS),
  parameter int EW        = ID_WIDTH + 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   instr_valid_i,
  output logic                   instr_ready_o,
  input  logic [ID_WIDTH-1:0]    instr_id_i,
  input  logic [N_SRC*AW-1:0]    rs_addr_i,
  input  logic [N_SRC-1:0]       rs_valid_i,
  input  logic [AW-1:0]          rd_addr_i,
  input  logic                   rd_valid_i,
  output logic [N_REGS*EW-1:0]   rw_queue_entry_o,
  output logic [N_REGS-1:0]      rw_queue_push_o,
  input  logic [N_REGS-1:0]      rw_queue_full_i,
  output logic                   busy_o,
  output logic [CNT_WIDTH-1:0]   stall_cnt_o
);

  dispatcher_state_e      state_q;
  logic [N_REGS-1:0]      pending_q;
  logic [N_REGS*EW-1:0]   entries_q;
  logic [CNT_WIDTH-1:0]   stall_cnt_q;

  logic [N_REGS*EW-1:0]   dec_entries;
  logic [N_REGS-1:0]      dec_target;
  logic [N_REGS-1:0]      blocked;
  logic [N_REGS-1:0]      pending_next;
  logic                   accept;

  quadrilatero_operand_merge #(
    .N_REGS   (N_REGS),
    .N_SRC    (N_SRC),
    .ID_WIDTH (ID_WIDTH),
    .AW       (AW),
    .EW       (EW)
  ) u_operand_merge (
    .instr_id_i (instr_id_i),
    .rs_addr_i  (rs_addr_i),
    .rs_valid_i (rs_valid_i),
    .rd_addr_i  (rd_addr_i),
    .rd_valid_i (rd_valid_i),
    .entries_o  (dec_entries),
    .target_o   (dec_target)
  );

  // Push gating and accept: a new instruction may load only once every pending register drains this cycle
  always_comb begin
    rw_queue_push_o = '0;
    instr_ready_o   = 1'b0;
    blocked         = pending_q & rw_queue_full_i;
    if (!rst_i) begin
      if (state_q == ISSUE) begin
        rw_queue_push_o = pending_q & ~rw_queue_full_i;
        instr_ready_o   = (blocked == '0);
      end else begin
        instr_ready_o   = 1'b1;
      end
    end
    pending_next = pending_q & ~rw_queue_push_o;
    accept       = instr_valid_i & instr_ready_o;
  end

  // Dispatcher FSM with latched entries and per-register pending mask
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      pending_q <= '0;
      entries_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept && (dec_target != '0)) begin
            entries_q <= dec_entries;
            pending_q <= dec_target;
            state_q   <= ISSUE;
          end
        end
        ISSUE: begin
          if (accept && (dec_target != '0)) begin
            entries_q <= dec_entries;
            pending_q <= dec_target;
          end else begin
            pending_q <= pending_next;
            if (pending_next == '0) begin
              state_q <= IDLE;
            end
          end
        end
        default: begin
          state_q   <= IDLE;
          pending_q <= '0;
        end
      endcase
    end
  end

  // Saturating count of ISSUE cycles where some pending register is held off by a full queue
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
    end else if ((state_q == ISSUE) && (blocked != '0) &&
                 (stall_cnt_q != {CNT_WIDTH{1'b1}})) begin
      stall_cnt_q <= stall_cnt_q + CNT_WIDTH'(1);
    end
  end

  assign rw_queue_entry_o = entries_q;
  assign busy_o           = (state_q == ISSUE);
  assign stall_cnt_o      = stall_cnt_q;

endmodule

// File: tb/tb_quadrilatero_rw_queue_dispatcher.sv
// tb/tb_quadrilatero_rw_queue_dispatcher.sv - self-checking bench for the rw_queue dispatcher
module tb_quadrilatero_rw_queue_dispatcher;

  localparam int NR = 8;
  localparam int NS = 3;
  localparam int IW = 4;
  localparam int CW = 16;
  localparam int AW = 3;
  localparam int EW = IW + 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              iv;
  logic              ir;
  logic [IW-1:0]     id;
  logic [NS*AW-1:0]  rsa;
  logic [NS-1:0]     rsv;
  logic [AW-1:0]     rda;
  logic              rdv;
  logic [NR*EW-1:0]  ent;
  logic [NR-1:0]     push;
  logic [NR-1:0]     full;
  logic              busy;
  logic [CW-1:0]     stall;

  int n_checks = 0;
  int n_fail   = 0;

  logic [EW-1:0] expq [NR][$];
  int            m_stall;

  always #5 clk = ~clk;

  quadrilatero_rw_queue_dispatcher #(
    .N_REGS    (NR),
    .N_SRC     (NS),
    .ID_WIDTH  (IW),
    .CNT_WIDTH (CW)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .instr_valid_i    (iv),
    .instr_ready_o    (ir),
    .instr_id_i       (id),
    .rs_addr_i        (rsa),
    .rs_valid_i       (rsv),
    .rd_addr_i        (rda),
    .rd_valid_i       (rdv),
    .rw_queue_entry_o (ent),
    .rw_queue_push_o  (push),
    .rw_queue_full_i  (full),
    .busy_o           (busy),
    .stall_cnt_o      (stall)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NR-1:0] m_pending();
    logic [NR-1:0] p;
    p = '0;
    for (int r = 0; r < NR; r++) p[r] = (expq[r].size() > 0);
    return p;
  endfunction

  function automatic logic [EW-1:0] entry_of(input int r);
    return ent[r*EW +: EW];
  endfunction

  // One clock: drive at negedge, check against the model, advance the model at posedge
  task automatic step(input logic v, input logic [IW-1:0] i_id, input logic [NS*AW-1:0] a,
                      input logic [NS-1:0] av, input logic [AW-1:0] d, input logic dv,
                      input logic [NR-1:0] f);
    logic [NR-1:0] pend;
    logic [NR-1:0] exp_push;
    logic          exp_ready;
    logic          rd_hit;
    logic          wr_hit;
    iv = v; id = i_id; rsa = a; rsv = av; rda = d; rdv = dv; full = f;
    #1;
    pend      = m_pending();
    exp_push  = pend & ~f;
    exp_ready = ((pend & f) == '0);
    chk("ready", 64'(ir), 64'(exp_ready));
    chk("push", 64'(push), 64'(exp_push));
    chk("busy", 64'(busy), 64'(pend != '0));
    chk("stall", 64'(stall), 64'(m_stall));
    for (int r = 0; r < NR; r++) begin
      if (exp_push[r] && push[r]) chk("entry", 64'(entry_of(r)), 64'(expq[r][0]));
    end
    @(posedge clk);
    for (int r = 0; r < NR; r++) begin
      if (exp_push[r]) void'(expq[r].pop_front());
    end
    if (((pend & f) != '0) && (m_stall < 65535)) m_stall++;
    if (v && exp_ready) begin
      for (int r = 0; r < NR; r++) begin
        rd_hit = 1'b0;
        for (int i = 0; i < NS; i++) begin
          if (av[i] && (int'(a[i*AW +: AW]) == r)) rd_hit = 1'b1;
        end
        wr_hit = dv && (int'(d) == r);
        if (rd_hit || wr_hit) expq[r].push_back({i_id, wr_hit, rd_hit});
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input logic [NR-1:0] f);
    step(1'b0, '0, '0, '0, '0, 1'b0, f);
  endtask

  task automatic drive_idle(input logic [NR-1:0] f);
    iv = 1'b0; rsv = '0; rdv = 1'b0; full = f;
    #1;
  endtask

  task automatic model_clear();
    for (int r = 0; r < NR; r++) expq[r].delete();
    m_stall = 0;
  endtask

  initial begin
    logic [NS*AW-1:0] ra;
    rst = 1'b1; iv = 1'b0; id = '0; rsa = '0; rsv = '0; rda = '0; rdv = 1'b0; full = '0;
    model_clear();
    @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 64'(ir), 64'd0);
    chk("rst_push", 64'(push), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_entry", 64'(ent), 64'd0);
    rst = 1'b0;

    // No backpressure: rs={1,2,3}, rd=0
    step(1'b1, 4'd5, {3'd3, 3'd2, 3'd1}, 3'b111, 3'd0, 1'b1, '0);
    drive_idle('0);
    chk("nobp_push", 64'(push), 64'h0F);
    chk("nobp_e0", 64'(entry_of(0)), 64'({4'd5, 1'b1, 1'b0}));
    chk("nobp_e1", 64'(entry_of(1)), 64'({4'd5, 1'b0, 1'b1}));
    chk("nobp_e3", 64'(entry_of(3)), 64'({4'd5, 1'b0, 1'b1}));
    idle('0);
    chk("nobp_idle", 64'(busy), 64'd0);

    // Merge: duplicate source plus rd on the same register
    step(1'b1, 4'd9, {3'd0, 3'd4, 3'd4}, 3'b011, 3'd4, 1'b1, '0);
    drive_idle('0);
    chk("merge_push", 64'(push), 64'h10);
    chk("merge_e4", 64'(entry_of(4)), 64'({4'd9, 1'b1, 1'b1}));
    idle('0);

    // Backpressure on register 2 for three cycles
    step(1'b1, 4'd3, {3'd0, 3'd2, 3'd1}, 3'b011, 3'd0, 1'b0, '0);
    drive_idle(8'h04);
    chk("bp_push1", 64'(push), 64'h02);
    chk("bp_ready1", 64'(ir), 64'd0);
    idle(8'h04);
    idle(8'h04);
    idle(8'h04);
    drive_idle('0);
    chk("bp_stall", 64'(stall), 64'd3);
    chk("bp_push2", 64'(push), 64'h04);
    chk("bp_ready4", 64'(ir), 64'd1);
    idle('0);

    // Back-to-back: second instruction accepted in the first one's push cycle
    step(1'b1, 4'd1, {3'd0, 3'd0, 3'd6}, 3'b001, 3'd0, 1'b0, '0);
    step(1'b1, 4'd2, {3'd0, 3'd0, 3'd0}, 3'b000, 3'd7, 1'b1, '0);
    drive_idle('0);
    chk("b2b_push", 64'(push), 64'h80);
    chk("b2b_e7", 64'(entry_of(7)), 64'({4'd2, 1'b1, 1'b0}));
    idle('0);

    // Empty operation
    step(1'b1, 4'd11, '0, 3'b000, 3'd0, 1'b0, '0);
    drive_idle('0);
    chk("empty_busy", 64'(busy), 64'd0);
    chk("empty_push", 64'(push), 64'd0);
    idle('0);

    // Randomized traffic against the queue model
    for (int n = 0; n < 400; n++) begin
      ra = NS*AW'($urandom);
      step(($urandom_range(0, 9) < 7), IW'($urandom), ra, NS'($urandom), AW'($urandom),
           1'($urandom), NR'($urandom & $urandom));
    end
    for (int n = 0; n < 40; n++) idle('0);

    // Reset while blocked in ISSUE
    step(1'b1, 4'd6, {3'd5, 3'd3, 3'd1}, 3'b111, 3'd2, 1'b1, '0);
    idle(8'hFF);
    idle(8'hFF);
    rst = 1'b1;
    drive_idle(8'hFF);
    chk("mrst_push", 64'(push), 64'd0);
    chk("mrst_ready", 64'(ir), 64'd0);
    @(posedge clk);
    model_clear();
    @(negedge clk);
    chk("mrst_busy", 64'(busy), 64'd0);
    chk("mrst_stall", 64'(stall), 64'd0);
    rst = 1'b0;
    idle(8'hFF);
    idle('0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
